pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use hazard flag from the hazard detector, taken-branch resolution in ID, multi-cycle multiply/divide occupancy of EX, and data-memory wait states. It drives per-stage register write enables and bubble/flush controls. It also keeps a stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_stall_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             lu_hazard_i,
    input  logic             branch_taken_i,
    input  logic             mdu_start_i,
    input  logic             mem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             ex_mem_bubble_o,
    output logic             mem_wb_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MCW = $clog2(MDU_LAT);
    localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LAT - 1);
    localparam logic [MCW-1:0] MDU_ONE  = MCW'(1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_MDU  = 2'b10;
    localparam logic [1:0] S_MEMW = 2'b11;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [MCW-1:0]   mdu_cnt;
    logic [MCW-1:0]   mdu_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_wait;
    logic             run_tail;

    assign mem_wait    = mem_req_i & ~dmem_ack_i;
    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;

    // Decode stage controls and next state from current state and hazard inputs
    always_comb begin
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_write_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_write_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        mem_wb_bubble_o = 1'b0;
        state_nxt       = state;
        mdu_cnt_nxt     = mdu_cnt;
        run_tail        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!start_i) begin
                    state_nxt = S_IDLE;
                end else if (mem_wait) begin
                    mem_wb_bubble_o = 1'b1;
                    state_nxt       = S_MEMW;
                end else begin
                    run_tail = 1'b1;
                end
            end
            S_MDU: begin
                if (mem_wait) begin
                    // Memory stall dominates; the MDU keeps counting but never past 1
                    mem_wb_bubble_o = 1'b1;
                    if (mdu_cnt > MDU_ONE) begin
                        mdu_cnt_nxt = mdu_cnt - MDU_ONE;
                    end
                end else if (mdu_cnt == MDU_ONE) begin
                    pc_write_o     = 1'b1;
                    if_id_write_o  = 1'b1;
                    id_ex_write_o  = 1'b1;
                    ex_mem_write_o = 1'b1;
                    state_nxt      = S_RUN;
                end else begin
                    ex_mem_write_o  = 1'b1;
                    ex_mem_bubble_o = 1'b1;
                    mdu_cnt_nxt     = mdu_cnt - MDU_ONE;
                end
            end
            default: begin
                // MEMW: hold until the access completes; start_i waits for RUN
                if (!dmem_ack_i) begin
                    mem_wb_bubble_o = 1'b1;
                end else begin
                    run_tail = 1'b1;
                end
            end
        endcase

        if (run_tail) begin
            state_nxt      = S_RUN;
            ex_mem_write_o = 1'b1;
            if (mdu_start_i) begin
                ex_mem_bubble_o = 1'b1;
                mdu_cnt_nxt     = MDU_LOAD;
                state_nxt       = S_MDU;
            end else if (lu_hazard_i) begin
                id_ex_write_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                if_id_write_o = 1'b1;
                id_ex_write_o = 1'b1;
                if_id_flush_o = branch_taken_i;
            end
        end

        if (rst_i) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            if_id_flush_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            id_ex_bubble_o  = 1'b0;
            ex_mem_write_o  = 1'b0;
            ex_mem_bubble_o = 1'b0;
            mem_wb_bubble_o = 1'b0;
        end
    end

    // State and MDU occupancy counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // Saturating count of cycles where the running pipeline did not advance the PC
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if ((state != S_IDLE) && !pc_write_o && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, lu, br, mdu, mreq, ack;
    logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, exmem_b, memwb_b;
    logic [1:0] state;
    logic [CNT_W-1:0] scnt;

    pipe_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .lu_hazard_i(lu),
        .branch_taken_i(br), .mdu_start_i(mdu), .mem_req_i(mreq), .dmem_ack_i(ack),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_id_flush_o(ifid_f),
        .id_ex_write_o(idex_w), .id_ex_bubble_o(idex_b), .ex_mem_write_o(exmem_w),
        .ex_mem_bubble_o(exmem_b), .mem_wb_bubble_o(memwb_b),
        .state_o(state), .stall_cnt_o(scnt)
    );

    // ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, exmem_b, memwb_b}
    typedef struct packed {
        logic [7:0]       ctl;
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 run, 2 multiply/divide, 3 memory wait
    int m_mode = 0;
    int m_left = 0;
    int m_cnt  = 0;

    // Pipeline view: stages 0..k-1 (PC, IF/ID, ID/EX, EX/MEM) frozen, NOP injected at stage k
    function automatic logic [7:0] freeze_ctl(input int k, input bit flush);
        logic [7:0] c;
        c[7] = (k <= 0);
        c[6] = (k <= 1);
        c[5] = flush;
        c[4] = (k <= 2);
        c[3] = (k == 2);
        c[2] = (k <= 3);
        c[1] = (k == 3);
        c[0] = (k == 4);
        return c;
    endfunction

    task automatic cycle(input bit st, input bit l, input bit b, input bit md,
                         input bit mr, input bit ak, input bit rs);
        exp_t e;
        int   nxt_mode;
        int   nxt_left;
        bit   run_tail;
        start = st; lu = l; br = b; mdu = md; mreq = mr; ack = ak; rst = rs;
        e.st  = 2'(m_mode);
        e.cnt = CNT_W'(m_cnt);
        e.ctl = 8'h00;
        nxt_mode = m_mode;
        nxt_left = m_left;
        run_tail = 1'b0;
        if (!rs) begin
            case (m_mode)
                0: if (st) nxt_mode = 1;
                1: begin
                    if (!st) nxt_mode = 0;
                    else if (mr && !ak) begin e.ctl = freeze_ctl(4, 0); nxt_mode = 3; end
                    else run_tail = 1'b1;
                end
                2: begin
                    if (mr && !ak) begin
                        e.ctl = freeze_ctl(4, 0);
                        nxt_left = (m_left > 1) ? m_left - 1 : 1;
                    end else if (m_left == 1) begin
                        e.ctl = freeze_ctl(0, 0);
                        nxt_mode = 1;
                    end else begin
                        e.ctl = freeze_ctl(3, 0);
                        nxt_left = m_left - 1;
                    end
                end
                default: begin
                    if (!ak) e.ctl = freeze_ctl(4, 0);
                    else run_tail = 1'b1;
                end
            endcase
            if (run_tail) begin
                nxt_mode = 1;
                if (md) begin e.ctl = freeze_ctl(3, 0); nxt_mode = 2; nxt_left = MDU_LAT - 1; end
                else if (l) e.ctl = freeze_ctl(2, 0);
                else e.ctl = freeze_ctl(0, b);
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        if (rs) begin
            m_mode = 0; m_left = 0; m_cnt = 0;
        end else begin
            if (m_mode != 0 && !e.ctl[7] && m_cnt < CNT_MAX) m_cnt++;
            m_mode = nxt_mode;
            m_left = nxt_left;
        end
        #1;
    endtask

    // Monitor: pops the expected response for the cycle and checks outputs and invariants
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, exmem_b, memwb_b};
                n_tests++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl t=%0t actual=%b expected=%b", $time, act, e.ctl);
                end
                n_tests++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state t=%0t actual=%b expected=%b", $time, state, e.st);
                end
                n_tests++;
                if (scnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_cnt t=%0t actual=%0d expected=%0d", $time, scnt, e.cnt);
                end
                n_tests++;
                if ((ifid_f && !ifid_w) || (idex_b && !idex_w) || (exmem_b && !exmem_w)
                    || (ifid_f && idex_b)) begin
                    n_fail++;
                    $display("FAIL invariant t=%0t actual=%b expected=no bubble without write", $time, act);
                end
            end
        end
    end

    initial begin
        int k;
        bit rs, st, l, b, md, mr, ak;
        rst = 1'b1; start = 0; lu = 0; br = 0; mdu = 0; mreq = 0; ack = 0;
        @(posedge clk);
        #1;
        // Reset, then clean run
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
        // Load-use stall
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Load-use masks a branch, then the branch flushes
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // MDU occupancy
        cycle(1, 0, 0, 1, 0, 0, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0, 0);
        // Memory wait of 3 cycles
        repeat (3) cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Memory wait of 5 cycles during MDU; counter pins at 1
        cycle(1, 0, 0, 1, 0, 0, 0);
        repeat (5) cycle(1, 1, 1, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Reset mid memory wait
        repeat (2) cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Stop from RUN
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            st = (m_mode >= 2) ? 1'b1 : ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            md = ($urandom_range(0, 5) == 0);
            mr = (m_mode == 3) ? 1'b1 : ($urandom_range(0, 3) == 0);
            ak = $urandom_range(0, 1) != 0;
            cycle(st, l, b, md, mr, ak, rs);
        end
        k = 0;
        while (sb_q.size() > 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
